// File: rtl/arith_decode_queue_if.sv
// Handshake and decoded-field bundle between fetch, the decode queue and the arith machine.
// The master side is fetch plus the arith machine; the slave side is the queue itself.
interface arith_decode_queue_if;
    logic [31:0] inst_in;
    logic        inst_valid;
    logic        inst_ready;
    logic        stall;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rd_src;
    logic        wr_enable;
    logic [1:0]  alu_src2;
    logic [2:0]  alu_op;
    logic [15:0] imm16;
    logic        NOT;
    logic        illegal;
    logic [7:0]  issued_count;

    modport master (
        output inst_in, inst_valid, stall,
        input  inst_ready, rs, rt, rd, rd_src, wr_enable, alu_src2, alu_op,
               imm16, NOT, illegal, issued_count
    );

    modport slave (
        input  inst_in, inst_valid, stall,
        output inst_ready, rs, rt, rd, rd_src, wr_enable, alu_src2, alu_op,
               imm16, NOT, illegal, issued_count
    );
endinterface

// File: rtl/arith_decode_queue.sv
// Two-entry instruction queue that decodes a small MIPS arithmetic subset at its head
// and issues registered control fields; an unsupported head halts the queue until reset.
module arith_decode_queue (
    input  logic                 clk,
    input  logic                 rst_n,
    arith_decode_queue_if.slave  q
);
    typedef enum logic {RUN, HALT} state_e;

    state_e      state_q, state_d;
    logic [31:0] mem_q [2];
    logic        head_q;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_word;
    logic        wr_ptr;

    logic        dec_legal;
    logic [2:0]  dec_op;
    logic [1:0]  dec_src2;
    logic        dec_rd_src;

    logic        push, pop, halt_now;

    logic [4:0]  rs_q, rt_q, rd_q;
    logic        rd_src_q, wr_en_q, illegal_q;
    logic [1:0]  alu_src2_q;
    logic [2:0]  alu_op_q;
    logic [15:0] imm16_q;
    logic [7:0]  issued_q;

    assign head_word = mem_q[head_q];
    assign wr_ptr    = head_q ^ count_q[0];

    always_comb begin
        dec_legal  = 1'b1;
        dec_op     = 3'b000;
        dec_src2   = 2'b00;
        dec_rd_src = 1'b0;
        case (head_word[31:26])
            6'h00: begin
                case (head_word[5:0])
                    6'h20:   dec_op = 3'b010;
                    6'h22:   dec_op = 3'b011;
                    6'h24:   dec_op = 3'b100;
                    6'h25:   dec_op = 3'b101;
                    6'h27:   dec_op = 3'b110;
                    6'h26:   dec_op = 3'b111;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: begin dec_op = 3'b010; dec_src2 = 2'b01; dec_rd_src = 1'b1; end
            6'h0c: begin dec_op = 3'b100; dec_src2 = 2'b10; dec_rd_src = 1'b1; end
            6'h0d: begin dec_op = 3'b101; dec_src2 = 2'b10; dec_rd_src = 1'b1; end
            6'h0e: begin dec_op = 3'b111; dec_src2 = 2'b10; dec_rd_src = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
    end

    // Ready is gated by rst_n so it reads 0 for the whole time reset is held.
    always_comb begin
        state_d      = state_q;
        q.inst_ready = rst_n && (count_q != 2'd2) && (state_q == RUN);
        push         = q.inst_valid && q.inst_ready;
        pop          = (count_q != 2'd0) && !q.stall && (state_q == RUN) && dec_legal;
        halt_now     = (count_q != 2'd0) && !q.stall && (state_q == RUN) && !dec_legal;
        if (halt_now) state_d = HALT;
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 2'd1;
        else if (pop && !push) count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            head_q  <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) mem_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            head_q  <= head_q ^ pop;
            if (push) mem_q[wr_ptr] <= q.inst_in;
        end
    end

    // Field registers only load on issue, so they hold the last issued instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            rd_q       <= 5'd0;
            rd_src_q   <= 1'b0;
            alu_src2_q <= 2'b00;
            alu_op_q   <= 3'b000;
            imm16_q    <= 16'd0;
            wr_en_q    <= 1'b0;
            illegal_q  <= 1'b0;
            issued_q   <= 8'd0;
        end else begin
            wr_en_q <= pop;
            if (halt_now) illegal_q <= 1'b1;
            if (pop) begin
                rs_q       <= head_word[25:21];
                rt_q       <= head_word[20:16];
                rd_q       <= head_word[15:11];
                rd_src_q   <= dec_rd_src;
                alu_src2_q <= dec_src2;
                alu_op_q   <= dec_op;
                imm16_q    <= head_word[15:0];
                issued_q   <= issued_q + 8'd1;
            end
        end
    end

    assign q.rs           = rs_q;
    assign q.rt           = rt_q;
    assign q.rd           = rd_q;
    assign q.rd_src       = rd_src_q;
    assign q.alu_src2     = alu_src2_q;
    assign q.alu_op       = alu_op_q;
    assign q.imm16        = imm16_q;
    assign q.wr_enable    = wr_en_q;
    assign q.NOT          = wr_en_q;
    assign q.illegal      = illegal_q;
    assign q.issued_count = issued_q;
endmodule

// File: tb/tb_arith_decode_queue.sv
// Directed-vector bench for arith_decode_queue: one task per scenario with inline checks.
module tb_arith_decode_queue;
    logic clk;
    logic rst_n;
    int   nCompared;
    int   nMismatched;

    arith_decode_queue_if q ();

    arith_decode_queue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        q.inst_in    = 32'd0;
        q.inst_valid = 1'b0;
        q.stall      = 1'b0;
        #1;
        check("rst_ready_low", {31'd0, q.inst_ready}, 32'd0);
        check("rst_wr_enable", {31'd0, q.wr_enable}, 32'd0);
        check("rst_not", {31'd0, q.NOT}, 32'd0);
        check("rst_illegal", {31'd0, q.illegal}, 32'd0);
        check("rst_count", {24'd0, q.issued_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready_high", {31'd0, q.inst_ready}, 32'd1);
        tick();
    endtask

    // addi $2,$0,0xaaa
    task automatic test_addi();
        q.inst_in    = 32'h2002_0AAA;
        q.inst_valid = 1'b1;
        tick();
        q.inst_valid = 1'b0;
        check("addi_no_early_wr", {31'd0, q.wr_enable}, 32'd0);
        tick();
        check("addi_rs", {27'd0, q.rs}, 32'd0);
        check("addi_rt", {27'd0, q.rt}, 32'd2);
        check("addi_rd_src", {31'd0, q.rd_src}, 32'd1);
        check("addi_src2", {30'd0, q.alu_src2}, 32'd1);
        check("addi_op", {29'd0, q.alu_op}, 32'd2);
        check("addi_imm", {16'd0, q.imm16}, 32'h0AAA);
        check("addi_wr", {31'd0, q.wr_enable}, 32'd1);
        check("addi_not", {31'd0, q.NOT}, 32'd1);
        check("addi_count", {24'd0, q.issued_count}, 32'd1);
        tick();
        check("addi_wr_drop", {31'd0, q.wr_enable}, 32'd0);
        check("addi_not_drop", {31'd0, q.NOT}, 32'd0);
        check("addi_imm_hold", {16'd0, q.imm16}, 32'h0AAA);
    endtask

    // nor $1,$2,$3
    task automatic test_nor();
        q.inst_in    = 32'h0043_0827;
        q.inst_valid = 1'b1;
        tick();
        q.inst_valid = 1'b0;
        tick();
        check("nor_rs", {27'd0, q.rs}, 32'd2);
        check("nor_rt", {27'd0, q.rt}, 32'd3);
        check("nor_rd", {27'd0, q.rd}, 32'd1);
        check("nor_rd_src", {31'd0, q.rd_src}, 32'd0);
        check("nor_src2", {30'd0, q.alu_src2}, 32'd0);
        check("nor_op", {29'd0, q.alu_op}, 32'd6);
        check("nor_wr", {31'd0, q.wr_enable}, 32'd1);
        check("nor_count", {24'd0, q.issued_count}, 32'd2);
        tick();
        check("nor_wr_drop", {31'd0, q.wr_enable}, 32'd0);
    endtask

    // add $4,$5,$6 / sub $7,$8,$9 / andi $10,$11,0xf0 pushed while stalled
    task automatic test_back_to_back();
        q.stall      = 1'b1;
        q.inst_in    = 32'h00A6_2020;
        q.inst_valid = 1'b1;
        tick();
        check("b2b_ready_after_one", {31'd0, q.inst_ready}, 32'd1);
        q.inst_in = 32'h0109_3822;
        tick();
        q.inst_in = 32'h316A_00F0;
        check("b2b_ready_full", {31'd0, q.inst_ready}, 32'd0);
        tick();
        check("b2b_stall_no_wr", {31'd0, q.wr_enable}, 32'd0);
        q.stall = 1'b0;
        tick();
        check("b2b_first_wr", {31'd0, q.wr_enable}, 32'd1);
        check("b2b_first_rd", {27'd0, q.rd}, 32'd4);
        check("b2b_first_op", {29'd0, q.alu_op}, 32'd2);
        check("b2b_ready_again", {31'd0, q.inst_ready}, 32'd1);
        tick();
        q.inst_valid = 1'b0;
        check("b2b_second_wr", {31'd0, q.wr_enable}, 32'd1);
        check("b2b_second_rd", {27'd0, q.rd}, 32'd7);
        check("b2b_second_op", {29'd0, q.alu_op}, 32'd3);
        tick();
        check("b2b_third_wr", {31'd0, q.wr_enable}, 32'd1);
        check("b2b_third_rs", {27'd0, q.rs}, 32'd11);
        check("b2b_third_rt", {27'd0, q.rt}, 32'd10);
        check("b2b_third_op", {29'd0, q.alu_op}, 32'd4);
        check("b2b_third_src2", {30'd0, q.alu_src2}, 32'd2);
        check("b2b_third_imm", {16'd0, q.imm16}, 32'h00F0);
        check("b2b_count", {24'd0, q.issued_count}, 32'd5);
        tick();
        check("b2b_idle_wr", {31'd0, q.wr_enable}, 32'd0);
    endtask

    // ori $3,$0,0x1234 followed by lw
    task automatic test_illegal();
        q.inst_in    = 32'h3403_1234;
        q.inst_valid = 1'b1;
        tick();
        q.inst_in = 32'h8C00_0000;
        tick();
        q.inst_valid = 1'b0;
        check("ill_ori_wr", {31'd0, q.wr_enable}, 32'd1);
        check("ill_ori_op", {29'd0, q.alu_op}, 32'd5);
        check("ill_ori_src2", {30'd0, q.alu_src2}, 32'd2);
        check("ill_ori_imm", {16'd0, q.imm16}, 32'h1234);
        check("ill_ori_rt", {27'd0, q.rt}, 32'd3);
        check("ill_pre_flag", {31'd0, q.illegal}, 32'd0);
        tick();
        check("ill_flag", {31'd0, q.illegal}, 32'd1);
        check("ill_wr", {31'd0, q.wr_enable}, 32'd0);
        check("ill_ready", {31'd0, q.inst_ready}, 32'd0);
        q.inst_in    = 32'h3403_1234;
        q.inst_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ill_halt_wr", {31'd0, q.wr_enable}, 32'd0);
            check("ill_halt_ready", {31'd0, q.inst_ready}, 32'd0);
        end
        q.inst_valid = 1'b0;
        check("ill_sticky", {31'd0, q.illegal}, 32'd1);
        check("ill_count", {24'd0, q.issued_count}, 32'd6);
    endtask

    // xori $1,$1,1 streamed 256 times, then reset during the last pulse
    task automatic test_wrap_and_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("wrap_rst_illegal", {31'd0, q.illegal}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("wrap_ready", {31'd0, q.inst_ready}, 32'd1);
        q.inst_in    = 32'h3821_0001;
        q.inst_valid = 1'b1;
        for (int i = 0; i < 256; i++) tick();
        check("wrap_count_255", {24'd0, q.issued_count}, 32'd255);
        check("wrap_op", {29'd0, q.alu_op}, 32'd7);
        check("wrap_stream_wr", {31'd0, q.wr_enable}, 32'd1);
        tick();
        check("wrap_count_0", {24'd0, q.issued_count}, 32'd0);
        check("wrap_last_wr", {31'd0, q.wr_enable}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_wr", {31'd0, q.wr_enable}, 32'd0);
        check("midrst_not", {31'd0, q.NOT}, 32'd0);
        check("midrst_ready", {31'd0, q.inst_ready}, 32'd0);
        q.inst_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("postrst_wr", {31'd0, q.wr_enable}, 32'd0);
        tick();
        check("postrst_empty_wr", {31'd0, q.wr_enable}, 32'd0);
        check("postrst_count", {24'd0, q.issued_count}, 32'd0);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_addi();
        test_nor();
        test_back_to_back();
        test_illegal();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
